// File: rtl/fft_pkg.sv
// Shared types and constants for the in-place radix-2 FFT control path.
// Width helpers keep the interface, address generator and sequencer consistent.
package fft_pkg;

  localparam int N_LOG2_DEF = 3;
  localparam int DATA_W_DEF = 16;
  localparam int PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int tw_width(input int n_log2);
    return (n_log2 > 1) ? n_log2 - 1 : 1;
  endfunction

  function automatic int stage_width(input int n_log2);
    return (n_log2 > 1) ? $clog2(n_log2) : 1;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Bus between the stage sequencer and its data memory, twiddle ROM and butterfly.
// master = sequencer side, slave = memories/butterfly/control side.
interface fft_stage_sequencer_if
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int TW_W = tw_width(N_LOG2);

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr_a;
  logic [N_LOG2-1:0] rd_addr_b;
  logic [TW_W-1:0]   tw_addr;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] tw_data;
  logic [DATA_W-1:0] bf_a;
  logic [DATA_W-1:0] bf_b;
  logic [DATA_W-1:0] bf_w;
  logic [DATA_W-1:0] bf_x;
  logic [DATA_W-1:0] bf_y;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr_a;
  logic [N_LOG2-1:0] wr_addr_b;
  logic [DATA_W-1:0] wr_data_a;
  logic [DATA_W-1:0] wr_data_b;

  modport master (
    input  start, rd_data_a, rd_data_b, tw_data, bf_x, bf_y,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_a, bf_b, bf_w, wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

  modport slave (
    output start, rd_data_a, rd_data_b, tw_data, bf_x, bf_y,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_a, bf_b, bf_w, wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

endinterface

// File: rtl/fft_addr_gen.sv
// Combinational (stage, butterfly) -> operand addresses and twiddle index for an
// in-place radix-2 DIT FFT; shared by every memory-based stage controller.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter  int N_LOG2 = N_LOG2_DEF,
  localparam int ST_W   = stage_width(N_LOG2),
  localparam int TW_W   = tw_width(N_LOG2)
) (
  input  logic [ST_W-1:0]   i_stage,
  input  logic [TW_W-1:0]   i_k,
  output logic [N_LOG2-1:0] o_addr_a,
  output logic [N_LOG2-1:0] o_addr_b,
  output logic [TW_W-1:0]   o_tw
);

  logic [N_LOG2-1:0] w_half;
  logic [N_LOG2-1:0] w_pos;
  logic [N_LOG2-1:0] w_grp;
  int                w_tw_sh;

  always_comb begin
    w_half   = N_LOG2'(1) << i_stage;
    w_pos    = N_LOG2'(i_k) & (w_half - N_LOG2'(1));
    w_grp    = N_LOG2'(i_k) >> i_stage;
    // Group base is grp * 2 * half; pos never overlaps it, so OR is an add.
    o_addr_a = ((w_grp << i_stage) << 1) | w_pos;
    o_addr_b = o_addr_a + w_half;
    w_tw_sh  = N_LOG2 - 1 - int'(i_stage);
    o_tw     = TW_W'(w_pos << w_tw_sh);
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Walks every stage/butterfly of an N-point in-place FFT: issues operand reads,
// registers butterfly operands and results, and writes back 3 cycles later.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  fft_stage_sequencer_if.master bus
);

  localparam int         ST_W       = stage_width(N_LOG2);
  localparam int         TW_W       = tw_width(N_LOG2);
  localparam int         HALF       = 1 << (N_LOG2 - 1);
  localparam logic [TW_W-1:0] K_LAST     = TW_W'(HALF - 1);
  localparam logic [ST_W-1:0] STAGE_LAST = ST_W'(N_LOG2 - 1);
  localparam logic [1:0]      DRAIN_LAST = 2'(PIPE_DEPTH - 1);

  state_t            r_state;
  logic [ST_W-1:0]   r_stage;
  logic [TW_W-1:0]   r_k;
  logic [1:0]        r_drain;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [N_LOG2-1:0] r_rd_addr_a;
  logic [N_LOG2-1:0] r_rd_addr_b;
  logic [TW_W-1:0]   r_tw_addr;

  logic [PIPE_DEPTH-1:0]             r_pipe_v;
  logic [PIPE_DEPTH-1:0][N_LOG2-1:0] r_pipe_addr_a;
  logic [PIPE_DEPTH-1:0][N_LOG2-1:0] r_pipe_addr_b;
  logic [DATA_W-1:0] r_bf_a, r_bf_b, r_bf_w;
  logic [DATA_W-1:0] r_wr_data_a, r_wr_data_b;

  logic [ST_W-1:0]   w_gen_stage;
  logic [TW_W-1:0]   w_gen_k;
  logic [N_LOG2-1:0] w_addr_a;
  logic [N_LOG2-1:0] w_addr_b;
  logic [TW_W-1:0]   w_tw;

  // The generator looks one issue ahead so the read addresses can be registered.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    w_gen_stage = '0;
    w_gen_k     = '0;
    case (r_state)
      S_RUN: begin
        w_gen_stage = r_stage;
        w_gen_k     = r_k + TW_W'(1);
      end
      S_DRAIN: w_gen_stage = r_stage + ST_W'(1);
      default: ;
    endcase
  end

  fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
    .i_stage  (w_gen_stage),
    .i_k      (w_gen_k),
    .o_addr_a (w_addr_a),
    .o_addr_b (w_addr_b),
    .o_tw     (w_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stage     <= '0;
      r_k         <= '0;
      r_drain     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_tw_addr   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_RUN;
            r_stage     <= '0;
            r_k         <= '0;
            r_busy      <= 1'b1;
            r_rd_en     <= 1'b1;
            r_rd_addr_a <= w_addr_a;
            r_rd_addr_b <= w_addr_b;
            r_tw_addr   <= w_tw;
          end
        end
        S_RUN: begin
          if (r_k == K_LAST) begin
            r_state     <= S_DRAIN;
            r_drain     <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_addr   <= '0;
          end else begin
            r_k         <= r_k + TW_W'(1);
            r_rd_addr_a <= w_addr_a;
            r_rd_addr_b <= w_addr_b;
            r_tw_addr   <= w_tw;
          end
        end
        S_DRAIN: begin
          // Drain length matches the pipeline so stage s fully commits before s+1 reads.
          if (r_drain != DRAIN_LAST) begin
            r_drain <= r_drain + 2'd1;
          end else if (r_stage == STAGE_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state     <= S_RUN;
            r_stage     <= r_stage + ST_W'(1);
            r_k         <= '0;
            r_rd_en     <= 1'b1;
            r_rd_addr_a <= w_addr_a;
            r_rd_addr_b <= w_addr_b;
            r_tw_addr   <= w_tw;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_v      <= '0;
      r_pipe_addr_a <= '0;
      r_pipe_addr_b <= '0;
      r_bf_a        <= '0;
      r_bf_b        <= '0;
      r_bf_w        <= '0;
      r_wr_data_a   <= '0;
      r_wr_data_b   <= '0;
    end else begin
      r_pipe_v      <= {r_pipe_v[PIPE_DEPTH-2:0], r_rd_en};
      r_pipe_addr_a <= {r_pipe_addr_a[PIPE_DEPTH-2:0], r_rd_addr_a};
      r_pipe_addr_b <= {r_pipe_addr_b[PIPE_DEPTH-2:0], r_rd_addr_b};
      if (r_pipe_v[0]) begin
        r_bf_a <= bus.rd_data_a;
        r_bf_b <= bus.rd_data_b;
        r_bf_w <= bus.tw_data;
      end
      if (r_pipe_v[1]) begin
        r_wr_data_a <= bus.bf_x;
        r_wr_data_b <= bus.bf_y;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr_a = r_rd_addr_a;
  assign bus.rd_addr_b = r_rd_addr_b;
  assign bus.tw_addr   = r_tw_addr;
  assign bus.bf_a      = r_bf_a;
  assign bus.bf_b      = r_bf_b;
  assign bus.bf_w      = r_bf_w;
  assign bus.wr_en     = r_pipe_v[PIPE_DEPTH-1];
  assign bus.wr_addr_a = r_pipe_addr_a[PIPE_DEPTH-1];
  assign bus.wr_addr_b = r_pipe_addr_b[PIPE_DEPTH-1];
  assign bus.wr_data_a = r_wr_data_a;
  assign bus.wr_data_b = r_wr_data_b;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer (N=8): write-first memory model,
// twiddle ROM returning its index, and butterfly stub X=A+B, Y=A-W.
module tb_fft_stage_sequencer;

  logic clk;
  logic rst_n;
  logic preload;
  logic clr_stats;
  int   cyc;
  int   t0;
  int   n_vec;
  int   n_miss;

  fft_stage_sequencer_if #(.N_LOG2(3), .DATA_W(16)) bus ();

  fft_stage_sequencer #(.N_LOG2(3), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected issue order for N=8, written out rather than derived.
  localparam int TR_A [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  localparam int TR_B [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  localparam int TR_W [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  typedef struct { int a; int b; int tw; } rd_t;
  typedef struct { int a; int b; logic [15:0] x; logic [15:0] y; } wr_t;

  rd_t         rd_q [$];
  wr_t         wr_q [$];
  logic [15:0] exp_mem [8];
  logic [15:0] mem [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  assign bus.bf_x = bus.bf_a + bus.bf_b;
  assign bus.bf_y = bus.bf_a - bus.bf_w;

  function automatic logic [15:0] rd_word(input logic [2:0] a);
    if (bus.wr_en && bus.wr_addr_a == a) return bus.wr_data_a;
    if (bus.wr_en && bus.wr_addr_b == a) return bus.wr_data_b;
    return mem[a];
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'(i);
    end else if (bus.wr_en) begin
      mem[bus.wr_addr_a] <= bus.wr_data_a;
      mem[bus.wr_addr_b] <= bus.wr_data_b;
    end
    if (bus.rd_en) begin
      bus.rd_data_a <= rd_word(bus.rd_addr_a);
      bus.rd_data_b <= rd_word(bus.rd_addr_b);
      bus.tw_data   <= 16'(bus.tw_addr);
    end
  end

  int  rd_cnt, wr_cnt, busy_cnt, done_cnt;
  int  first_rd, first_wr, done_cyc, busy_first, busy_last;
  int  rel;
  rd_t mon_rd;
  wr_t mon_wr;

  always @(negedge clk) begin
    rel = cyc - t0;
    if (clr_stats) begin
      rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
      first_rd = -1; first_wr = -1; done_cyc = -1; busy_first = -1; busy_last = -1;
    end else begin
      if (bus.rd_en) begin
        // First read of a new stage: every earlier write must already be committed.
        if (rd_cnt > 0 && rd_cnt % 4 == 0) check("hazard_wr_before_rd", wr_cnt, rd_cnt);
        rd_cnt++;
        if (first_rd < 0) first_rd = rel;
        check("rd_q_nonempty", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          mon_rd = rd_q.pop_front();
          check("rd_addr_a", 32'(bus.rd_addr_a), mon_rd.a);
          check("rd_addr_b", 32'(bus.rd_addr_b), mon_rd.b);
          check("tw_addr", 32'(bus.tw_addr), mon_rd.tw);
        end
      end
      if (bus.wr_en) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = rel;
        check("wr_q_nonempty", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          mon_wr = wr_q.pop_front();
          check("wr_addr_a", 32'(bus.wr_addr_a), mon_wr.a);
          check("wr_addr_b", 32'(bus.wr_addr_b), mon_wr.b);
          check("wr_data_a", 32'(bus.wr_data_a), 32'(mon_wr.x));
          check("wr_data_b", 32'(bus.wr_data_b), 32'(mon_wr.y));
        end
      end
      if (bus.busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = rel;
      end
    end
  end

  // Build the software transform, queue expectations, reload memory, clear stats.
  task automatic arm();
    logic [15:0] sm [8];
    logic [15:0] x, y;
    int a, b, w;
    rd_q.delete();
    wr_q.delete();
    for (int i = 0; i < 8; i++) sm[i] = 16'(i);
    for (int j = 0; j < 12; j++) begin
      a = TR_A[j]; b = TR_B[j]; w = TR_W[j];
      x = sm[a] + sm[b];
      y = sm[a] - 16'(w);
      sm[a] = x;
      sm[b] = y;
      rd_q.push_back('{a, b, w});
      wr_q.push_back('{a, b, x, y});
    end
    for (int i = 0; i < 8; i++) exp_mem[i] = sm[i];
    clr_stats = 1'b1;
    preload   = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    @(negedge clk); #1;
    clr_stats = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - t0 < r) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    bus.start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_rd_en"}, 32'(bus.rd_en), 0);
    check({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    check({tag, "_rd_addr"}, 32'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}), 0);
    check({tag, "_bf_ab"}, {bus.bf_a, bus.bf_b}, 0);
    check({tag, "_bf_w"}, 32'(bus.bf_w), 0);
    check({tag, "_wr_addr"}, 32'({bus.wr_addr_a, bus.wr_addr_b}), 0);
    check({tag, "_wr_data"}, {bus.wr_data_a, bus.wr_data_b}, 0);
  endtask

  task automatic post_checks(input string tag);
    check({tag, "_first_rd"}, first_rd, 1);
    check({tag, "_first_wr"}, first_wr, 4);
    check({tag, "_done_cycle"}, done_cyc, 22);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_first"}, busy_first, 1);
    check({tag, "_busy_last"}, busy_last, 21);
    check({tag, "_busy_count"}, busy_cnt, 21);
    check({tag, "_rd_count"}, rd_cnt, 12);
    check({tag, "_wr_count"}, wr_cnt, 12);
    check({tag, "_rd_q_left"}, rd_q.size(), 0);
    check({tag, "_wr_q_left"}, wr_q.size(), 0);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    t0        = 0;
    rst_n     = 1'b0;
    preload   = 1'b0;
    clr_stats = 1'b1;
    bus.start = 1'b0;
    #1;
    check_quiet_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single start pulse: full trace, latency and final memory.
    arm();
    start_pulse();
    wait_rel(40);
    post_checks("pulse");

    // Start held high through DONE: only one transform may run.
    arm();
    @(posedge clk); #1;
    bus.start = 1'b1;
    t0 = cyc;
    wait_rel(23);
    bus.start = 1'b0;
    wait_rel(40);
    post_checks("held");

    // Second start pulse while busy is ignored.
    arm();
    start_pulse();
    wait_rel(10);
    bus.start = 1'b1;
    wait_rel(11);
    bus.start = 1'b0;
    wait_rel(40);
    post_checks("retrig");

    // Reset mid-transform: outputs clear at once, no done pulse.
    arm();
    start_pulse();
    wait_rel(12);
    #1 rst_n = 1'b0;
    #1;
    check_quiet_outputs("midrst");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_rel(35);
    check("midrst_done_count", done_cnt, 0);
    check("midrst_busy_after", 32'(bus.busy), 0);

    // A fresh start after reset runs a complete, correct transform.
    arm();
    start_pulse();
    wait_rel(40);
    post_checks("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
